// File: rtl/mtx_hop_pkg.sv
// rtl/mtx_hop_pkg.sv - shared widths and state encoding for the hop sequencer
package mtx_hop_pkg;

  localparam int PHASE_WIDTH_DEF = 24;
  localparam int HOP_AW_DEF      = 4;
  localparam int GAP_WIDTH_DEF   = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_GAP   = ST_GAP,
    S_LOAD  = ST_LOAD,
    S_RUN   = ST_RUN,
    S_DONE  = ST_DONE,
    S_ABORT = ST_ABORT
  } hop_state_e;

endpackage

// File: rtl/mtx_hop_table.sv
// rtl/mtx_hop_table.sv - per-hop phase increment register file, async read
module mtx_hop_table
  import mtx_hop_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int HOP_AW      = HOP_AW_DEF
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [HOP_AW-1:0]      wr_addr,
  input  logic [PHASE_WIDTH-1:0] wr_data,
  input  logic [HOP_AW-1:0]      rd_addr,
  output logic [PHASE_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << HOP_AW;

  // Contents are host-programmed before use, so the array carries no reset.
  logic [PHASE_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mtx_hop_sequencer.sv
// rtl/mtx_hop_sequencer.sv - steps the signal generator through the hop table
module mtx_hop_sequencer
  import mtx_hop_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int HOP_AW      = HOP_AW_DEF,
  parameter int GAP_WIDTH   = GAP_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [HOP_AW-1:0]      cfg_addr,
  input  logic [PHASE_WIDTH-1:0] cfg_data,
  input  logic [HOP_AW:0]        num_hops,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  input  logic                   loop_en,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   gen_hop_ready,
  input  logic                   gen_phase_tready,
  output logic                   gen_srst,
  output logic                   gen_phase_tvalid,
  output logic                   gen_phase_tlast,
  output logic [PHASE_WIDTH-1:0] gen_hop_phase_inc,
  output logic [HOP_AW-1:0]      hop_idx,
  output logic                   hop_start,
  output logic                   seq_done,
  output logic                   busy,
  output logic                   stall
);

  hop_state_e             state_q, state_d;
  logic [HOP_AW-1:0]      hop_idx_q, hop_idx_d;
  logic [HOP_AW:0]        num_hops_q, num_hops_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic [PHASE_WIDTH-1:0] inc_q, inc_d;
  logic [PHASE_WIDTH-1:0] tbl_rd_data;
  logic                   last_hop;

  assign last_hop = ({1'b0, hop_idx_q} == (num_hops_q - (HOP_AW+1)'(1)));

  always_comb begin
    state_d          = state_q;
    hop_idx_d        = hop_idx_q;
    num_hops_d       = num_hops_q;
    gap_d            = gap_q;
    gap_cnt_d        = gap_cnt_q;
    gen_srst         = 1'b0;
    gen_phase_tvalid = 1'b0;
    gen_phase_tlast  = 1'b0;
    hop_start        = 1'b0;
    seq_done         = 1'b0;
    stall            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          num_hops_d = num_hops;
          gap_d      = gap_cycles;
          if (num_hops == '0) begin
            state_d = S_DONE;
          end else begin
            hop_idx_d = '0;
            state_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        gen_srst  = 1'b1;
        hop_start = 1'b1;
        state_d   = stop ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        gen_phase_tvalid = 1'b1;
        gen_phase_tlast  = last_hop && !loop_en;
        stall            = !gen_phase_tready;
        if (stop) begin
          state_d = S_ABORT;
        end else if (gen_hop_ready) begin
          if (last_hop && !loop_en) begin
            state_d = S_DONE;
          end else begin
            hop_idx_d = last_hop ? '0 : hop_idx_q + HOP_AW'(1);
            if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = S_GAP;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_GAP: begin
        gen_srst = 1'b1;
        if (stop) begin
          state_d = S_ABORT;
        end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
          state_d = S_LOAD;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end
      S_DONE: begin
        seq_done = 1'b1;
        gen_srst = 1'b1;
        state_d  = S_IDLE;
      end
      S_ABORT: begin
        gen_srst = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Returning to IDLE clears the visible hop index so IDLE shows all-zero outputs.
    if (state_d == S_IDLE) begin
      hop_idx_d = '0;
    end
  end

  // Increment is captured as LOAD is entered, addressed by the hop about to load.
  always_comb begin
    inc_d = inc_q;
    if (state_d == S_LOAD) begin
      inc_d = tbl_rd_data;
    end else if (state_d == S_IDLE) begin
      inc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hop_idx_q  <= '0;
      num_hops_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      inc_q      <= '0;
    end else begin
      state_q    <= state_d;
      hop_idx_q  <= hop_idx_d;
      num_hops_q <= num_hops_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      inc_q      <= inc_d;
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign hop_idx           = hop_idx_q;
  assign gen_hop_phase_inc = inc_q;

  mtx_hop_table #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .HOP_AW     (HOP_AW)
  ) u_table (
    .clk    (clk),
    .wr_en  (cfg_we),
    .wr_addr(cfg_addr),
    .wr_data(cfg_data),
    .rd_addr(hop_idx_d),
    .rd_data(tbl_rd_data)
  );

endmodule

// File: tb/tb_mtx_hop_sequencer.sv
// tb/tb_mtx_hop_sequencer.sv - scoreboard bench for the hop sequencer
module tb_mtx_hop_sequencer;

  localparam int PW = 24;
  localparam int AW = 4;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [PW-1:0] cfg_data = '0;
  logic [AW:0]   num_hops = '0;
  logic [GW-1:0] gap_cycles = '0;
  logic          loop_en = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          gen_hop_ready;
  logic          gen_phase_tready = 1'b1;
  logic          gen_srst, gen_phase_tvalid, gen_phase_tlast;
  logic [PW-1:0] gen_hop_phase_inc;
  logic [AW-1:0] hop_idx;
  logic          hop_start, seq_done, busy, stall;

  always #5 clk = ~clk;

  mtx_hop_sequencer #(.PHASE_WIDTH(PW), .HOP_AW(AW), .GAP_WIDTH(GW)) dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .num_hops         (num_hops),
    .gap_cycles       (gap_cycles),
    .loop_en          (loop_en),
    .start            (start),
    .stop             (stop),
    .gen_hop_ready    (gen_hop_ready),
    .gen_phase_tready (gen_phase_tready),
    .gen_srst         (gen_srst),
    .gen_phase_tvalid (gen_phase_tvalid),
    .gen_phase_tlast  (gen_phase_tlast),
    .gen_hop_phase_inc(gen_hop_phase_inc),
    .hop_idx          (hop_idx),
    .hop_start        (hop_start),
    .seq_done         (seq_done),
    .busy             (busy),
    .stall            (stall)
  );

  typedef struct {
    bit            is_done;
    logic [AW-1:0] idx;
    logic [PW-1:0] inc;
    bit            tlast;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Generator model: raises hop-complete hop_len RUN cycles after reset clears.
  int   hop_len = 100;
  int   gen_cnt = 0;
  bit   gen_auto = 1'b1;
  logic model_ready = 1'b0;
  logic manual_ready = 1'b0;
  assign gen_hop_ready = gen_auto ? model_ready : manual_ready;

  bit   tlast_pending = 1'b0;
  bit   exp_tlast = 1'b0;
  int   gap_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset || gen_srst) begin
      gen_cnt     = 0;
      model_ready = 1'b0;
    end else if (gen_phase_tvalid) begin
      gen_cnt++;
      if (gen_cnt >= hop_len) model_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (tlast_pending && gen_phase_tvalid) begin
        check("tlast_first_run", 32'(gen_phase_tlast), 32'(exp_tlast));
        tlast_pending = 1'b0;
      end
      if (hop_start || seq_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: hop_start=%0b seq_done=%0b hop_idx=%0d, none expected",
                   hop_start, seq_done, hop_idx);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'({seq_done, hop_start}), e.is_done ? 32'd2 : 32'd1);
          if (!e.is_done) begin
            check("load_hop_idx", 32'(hop_idx), 32'(e.idx));
            check("load_phase_inc", 32'(gen_hop_phase_inc), 32'(e.inc));
            exp_tlast     = e.tlast;
            tlast_pending = 1'b1;
          end
        end
      end
      if (busy && gen_srst && !gen_phase_tvalid && !hop_start && !seq_done) gap_seen++;
    end
  end

  task automatic push_load(input int idx, input logic [PW-1:0] inc, input bit tl);
    exp_t e;
    e.is_done = 1'b0;
    e.idx     = idx[AW-1:0];
    e.inc     = inc;
    e.tlast   = tl;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.idx     = '0;
    e.inc     = '0;
    e.tlast   = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic tbl_write(input int a, input logic [PW-1:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a[AW-1:0];
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_hop(input int idx, input int max);
    int n = 0;
    @(negedge clk);
    while (!(hop_start && hop_idx == idx[AW-1:0]) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL wait_hop_timeout: hop %0d not loaded within %0d cycles", idx, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_srst", 32'(gen_srst), 32'd0);
    check("rst_tvalid", 32'(gen_phase_tvalid), 32'd0);
    check("rst_hop_idx", 32'(hop_idx), 32'd0);
    check("rst_phase_inc", 32'(gen_hop_phase_inc), 32'd0);
    check("rst_seq_done", 32'(seq_done), 32'd0);

    // Three hops, no gap, generator completes each hop after 100 RUN cycles.
    tbl_write(0, 24'h001000);
    tbl_write(1, 24'h002000);
    tbl_write(2, 24'h003000);
    num_hops = 5'd3; gap_cycles = 16'd0; loop_en = 1'b0; hop_len = 100;
    push_load(0, 24'h001000, 1'b0);
    push_load(1, 24'h002000, 1'b0);
    push_load(2, 24'h003000, 1'b1);
    push_done();
    pulse_start();
    check("start_to_load", 32'(hop_start), 32'd1);
    check("load_srst", 32'(gen_srst), 32'd1);
    @(negedge clk);
    check("load_to_run_tvalid", 32'(gen_phase_tvalid), 32'd1);
    wait_idle("seq3_idle", 1000);
    check("seq3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Guard gap of five cycles between two hops.
    num_hops = 5'd2; gap_cycles = 16'd5; hop_len = 10;
    gap_seen = 0;
    push_load(0, 24'h001000, 1'b0);
    push_load(1, 24'h002000, 1'b1);
    push_done();
    pulse_start();
    wait_idle("gap_idle", 200);
    check("gap_cycle_count", 32'(gap_seen), 32'd5);
    check("gap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Looping pair, table rewrite mid-hop, then drop loop_en to finish.
    num_hops = 5'd2; gap_cycles = 16'd0; loop_en = 1'b1;
    push_load(0, 24'h001000, 1'b0);
    push_load(1, 24'h002000, 1'b0);
    pulse_start();
    wait_hop(1, 200);
    push_load(0, 24'h001000, 1'b0);
    push_load(1, 24'hABCDEF, 1'b0);
    tbl_write(1, 24'hABCDEF);
    check("inc_held_after_write", 32'(gen_hop_phase_inc), 32'h002000);
    wait_hop(0, 200);
    wait_hop(1, 200);
    repeat (2) @(negedge clk);
    loop_en = 1'b0;
    push_done();
    wait_idle("loop_idle", 200);
    check("loop_queue_empty", 32'(exp_q.size()), 32'd0);

    // Empty sequence goes straight to DONE.
    num_hops = 5'd0;
    push_done();
    pulse_start();
    check("zero_hops_seq_done", 32'(seq_done), 32'd1);
    check("zero_hops_no_load", 32'(hop_start), 32'd0);
    @(negedge clk);
    check("zero_hops_idle", 32'(busy), 32'd0);

    // Stop coinciding with hop-complete aborts; stall reflects tready in RUN.
    gen_auto = 1'b0; manual_ready = 1'b0;
    num_hops = 5'd3; gap_cycles = 16'd0;
    push_load(0, 24'h001000, 1'b0);
    pulse_start();
    repeat (3) @(negedge clk);
    gen_phase_tready = 1'b0;
    @(negedge clk);
    check("run_stall", 32'(stall), 32'd1);
    gen_phase_tready = 1'b1;
    manual_ready = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    manual_ready = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_srst", 32'(gen_srst), 32'd1);
    check("abort_tvalid", 32'(gen_phase_tvalid), 32'd0);
    @(negedge clk);
    check("abort_to_idle", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start and stop together in IDLE are both ignored.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 32'(busy), 32'd0);
    gen_auto = 1'b1;

    // Reset mid-sequence returns to IDLE without a completion pulse.
    push_load(0, 24'h001000, 1'b0);
    pulse_start();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_seq_done", 32'(seq_done), 32'd0);
    check("midrst_phase_inc", 32'(gen_hop_phase_inc), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", 32'(busy), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
